// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
// Holds the fetch FSM encoding and the instruction-queue entry layout.
package riscv_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] RESET_VEC  = 32'h0000_0000;
  localparam int          ILEN_BYTES = 4;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush, occupancy count and same-cycle push/pop.
// A push in the flush cycle lands in the freshly emptied queue.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop & (count_reg != '0) & ~flush;
  assign do_push = push & (flush | (count_reg != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= do_push ? bump('0) : '0;
      count_reg  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

  // Storage carries no reset; the count alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? '0 : wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues word fetches, pairs in-order responses
// with their PCs, and buffers results for decode with redirect/flush handling.
module ifetch_unit #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = riscv_pkg::RESET_VEC,
  parameter int              QDEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_fault
);

  import riscv_pkg::*;

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int DW = 8;

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [DW-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]   inflight, q_count;
  logic [XLEN-1:0] pend_pc;
  fetch_entry_t    q_head, q_push_entry;
  logic            misaligned, req_fire, rsp_accept, q_push, credit_ok;

  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign credit_ok  = ({1'b0, inflight} + {1'b0, q_count}) < (CW + 1)'(QDEPTH);

  assign imem_req_valid = (state_reg == FS_RUN) & ~redirect_valid & credit_ok;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_accept     = imem_rsp_valid & ~redirect_valid & (drop_cnt_reg == '0);
  assign q_push         = rsp_accept | (redirect_valid & misaligned);

  // The pending-PC FIFO occupancy doubles as the in-flight request count.
  fetch_queue #(.DEPTH(QDEPTH), .WIDTH(XLEN)) u_pend_q (
    .clk       (clk),
    .rst_      (rst_),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_reg),
    .pop       (rsp_accept),
    .head      (pend_pc),
    .count     (inflight)
  );

  always_comb begin
    q_push_entry = '0;
    if (redirect_valid) begin
      q_push_entry.pc    = redirect_pc;
      q_push_entry.fault = 1'b1;
    end else begin
      q_push_entry.pc    = pend_pc;
      q_push_entry.instr = imem_rsp_err ? '0 : imem_rsp_data;
      q_push_entry.fault = imem_rsp_err;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_q (
    .clk       (clk),
    .rst_      (rst_),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_push_entry),
    .pop       (dec_ready),
    .head      (q_head),
    .count     (q_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FS_BOOT: state_next = FS_RUN;
      FS_RUN:  if (rsp_accept && imem_rsp_err) state_next = FS_HALT;
      default: state_next = state_reg;
    endcase
    if (redirect_valid) state_next = misaligned ? FS_HALT : FS_RUN;
  end

  // Responses to requests outstanding at a redirect are counted off as they return.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (redirect_valid)
      drop_cnt_next = drop_cnt_reg + DW'(inflight) - DW'(imem_rsp_valid);
    else if (imem_rsp_valid && drop_cnt_reg != '0)
      drop_cnt_next = drop_cnt_reg - DW'(1);
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_reg    <= FS_BOOT;
      fetch_pc_reg <= RESET_VEC;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      drop_cnt_reg <= drop_cnt_next;
      if (redirect_valid)
        fetch_pc_reg <= redirect_pc;
      else if (req_fire)
        fetch_pc_reg <= fetch_pc_reg + XLEN'(ILEN_BYTES);
    end
  end

  assign dec_valid = q_count != '0;
  assign dec_pc    = dec_valid ? q_head.pc    : '0;
  assign dec_instr = dec_valid ? q_head.instr : '0;
  assign dec_fault = dec_valid & q_head.fault;

endmodule
